// File: rtl/if_pkg.sv
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

  // Byte distance between consecutive instruction words
  localparam int unsigned PC_INC = 4;

  // Entries in the fetch buffer
  localparam int unsigned FIFO_DEPTH = 2;

endpackage : if_pkg

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// Module      : if_fetch_fifo
// Description : Two-entry buffer holding fetched {instr, PC} pairs between
//               instruction memory and decode. Flush wins over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] entry0_q;
  logic [WIDTH-1:0] entry1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;

  logic             w_do_push;
  logic             w_do_pop;

  // Overflowing pushes and underflowing pops are ignored
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  assign full_o  = (occ_q == 2'(FIFO_DEPTH));
  assign empty_o = (occ_q == 2'd0);
  assign occ_o   = occ_q;
  assign data_o  = rd_ptr_q ? entry1_q : entry0_q;

  // Storage, pointers and occupancy; a flush only clears the bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (w_do_push) begin
        if (wr_ptr_q) begin
          entry1_q <= data_i;
        end else begin
          entry0_q <= data_i;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (w_do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (w_do_push && !w_do_pop) begin
        occ_q <= occ_q + 2'd1;
      end else if (w_do_pop && !w_do_push) begin
        occ_q <= occ_q - 2'd1;
      end
    end
  end

endmodule : if_fetch_fifo

`default_nettype wire

// File: rtl/if_stage_fetch_unit.sv
// ============================================================================
// Module      : if_stage_fetch_unit
// Description : Instruction fetch stage. Issues sequential fetches from a
//               fetch pointer, buffers up to two returned words and hands
//               them to decode. Branch redirects flush the buffer; a redirect
//               that arrives while a request is still in flight waits for
//               that request's ack and throws its data away.
//               Optional feature: define IF_STALL_CNT_EN to add a saturating
//               32-bit counter of cycles where decode back-pressures a valid
//               instruction (output stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned             ADDRESS_LEN  = 32,
  parameter int unsigned             DATA_LEN     = 32,
  parameter logic [ADDRESS_LEN-1:0]  RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [DATA_LEN-1:0]    imem_rdata,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [DATA_LEN-1:0]    instr,
  output logic [ADDRESS_LEN-1:0] PC
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned ENTRY_W = DATA_LEN + ADDRESS_LEN;

  if_state_e              state_q;
  logic [ADDRESS_LEN-1:0] fpc_q;
  logic [ADDRESS_LEN-1:0] target_q;

  logic                   w_req;
  logic                   w_accept;
  logic [ADDRESS_LEN-1:0] w_fpc_next;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [1:0]             w_occ;
  logic [ENTRY_W-1:0]     w_head;

  // A request is outstanding in REQ while the buffer has room, and always in
  // DISCARD (the in-flight request must still be completed by its ack).
  assign w_req      = ((state_q == REQ) && (w_occ < 2'(FIFO_DEPTH))) ||
                      (state_q == DISCARD);
  assign w_accept   = (state_q == REQ) && w_req && imem_ack && !branch_taken;
  assign w_fpc_next = fpc_q + ADDRESS_LEN'(PC_INC);
  assign w_push     = w_accept && !w_full;
  assign w_pop      = if_valid && id_ready && !branch_taken;

  assign imem_req  = w_req;
  assign imem_addr = w_req ? fpc_q : '0;
  assign if_valid  = !w_empty;
  assign instr     = w_empty ? '0 : w_head[ENTRY_W-1:ADDRESS_LEN];
  assign PC        = w_empty ? '0 : w_head[ADDRESS_LEN-1:0];

  if_fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (branch_taken),
    .data_i  ({imem_rdata, w_fpc_next}),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .occ_o   (w_occ)
  );

  // Fetch controller: state, fetch pointer and pending redirect target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_VECTOR;
      target_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          if (branch_taken) begin
            fpc_q <= branch_addr;
          end
        end
        REQ: begin
          if (branch_taken) begin
            if (w_req && !imem_ack) begin
              // Request in flight: keep the address stable, redirect later
              target_q <= branch_addr;
              state_q  <= DISCARD;
            end else begin
              fpc_q <= branch_addr;
            end
          end else if (w_accept) begin
            fpc_q <= w_fpc_next;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            // The newest redirect wins if one lands together with the ack
            fpc_q   <= branch_taken ? branch_addr : target_q;
            state_q <= REQ;
          end else if (branch_taken) begin
            target_q <= branch_addr;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count back-pressured cycles, holding at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (if_valid && !id_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : if_stage_fetch_unit

`default_nettype wire

// File: tb/tb_if_stage_fetch_unit.sv
// ============================================================================
// Module      : tb_if_stage_fetch_unit
// Description : Self-checking bench for if_stage_fetch_unit. A queue-based
//               reference model tracks the expected fetch pointer and buffer
//               contents; directed scenarios pin it with literal values and
//               a randomized phase exercises acks, stalls and redirects.
//               Define IF_STALL_CNT_EN to also cover stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] PC;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  if_stage_fetch_unit #(
    .ADDRESS_LEN  (32),
    .DATA_LEN     (32),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .instr        (instr),
    .PC           (PC)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = first cycle after reset, 1 = fetching, 2 = waiting to drop
  // the in-flight word after a redirect.
  int          m_phase = 0;
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_tgt = 32'h0;
  logic [63:0] m_q[$];
  logic [31:0] m_stall = 32'h0;

  function automatic bit m_req();
    return (m_phase == 1 && m_q.size() < 2) || (m_phase == 2);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0;
        m_fpc   = 32'h0;
        m_tgt   = 32'h0;
        m_q.delete();
        m_stall = 32'h0;
      end else begin
        bit req;
        req = m_req();
        if (m_q.size() > 0 && !id_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        case (m_phase)
          0: begin
            m_phase = 1;
            if (branch_taken) m_fpc = branch_addr;
          end
          1: begin
            if (branch_taken) begin
              m_q.delete();
              if (req && !imem_ack) begin
                m_tgt   = branch_addr;
                m_phase = 2;
              end else begin
                m_fpc = branch_addr;
              end
            end else begin
              if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
              if (req && imem_ack) begin
                m_q.push_back({imem_rdata, m_fpc + 32'd4});
                m_fpc = m_fpc + 32'd4;
              end
            end
          end
          default: begin
            if (branch_taken) m_q.delete();
            if (imem_ack) begin
              m_fpc   = branch_taken ? branch_addr : m_tgt;
              m_phase = 1;
            end else if (branch_taken) begin
              m_tgt = branch_addr;
            end
          end
        endcase
      end
    end
  end

  // Compare every cycle, mid-way between rising edges
  initial begin
    forever begin
      @(negedge clk);
      chk("imem_req", imem_req, m_req());
      chk("imem_addr", imem_addr, m_req() ? m_fpc : 32'h0);
      chk("if_valid", if_valid, m_q.size() > 0);
      chk("instr", instr, (m_q.size() > 0) ? m_q[0][63:32] : 32'h0);
      chk("PC", PC, (m_q.size() > 0) ? m_q[0][31:0] : 32'h0);
`ifdef IF_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    id_ready     = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    int acks;
    int guard;

    do_reset();

    // Streaming fetch with decode always ready
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      imem_rdata = 32'hA000_0000 + i;
      imem_ack   = imem_req;
      if (imem_req) addrs.push_back(imem_addr);
      if (if_valid) pcs.push_back(PC);
    end
    chk("stream_n_addr", addrs.size() >= 3, 1);
    chk("stream_n_pc", pcs.size() >= 3, 1);
    if (addrs.size() >= 3 && pcs.size() >= 3) begin
      chk("stream_addr0", addrs[0], 32'h0);
      chk("stream_addr1", addrs[1], 32'h4);
      chk("stream_addr2", addrs[2], 32'h8);
      chk("stream_pc0", pcs[0], 32'h4);
      chk("stream_pc1", pcs[1], 32'h8);
      chk("stream_pc2", pcs[2], 32'hC);
    end

    // Decode stalled: buffer fills after two acks and requests stop
    do_reset();
    acks  = 0;
    guard = 0;
    while (acks < 2 && guard < 20) begin
      step();
      imem_rdata = 32'hB000_0000 + acks;
      imem_ack   = imem_req;
      if (imem_req) acks++;
      guard++;
    end
    chk("stall_two_acks", acks, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      imem_ack = imem_req;
      if (imem_req) acks++;
    end
    chk("stall_no_third_req", acks, 2);
    chk("stall_req_low", imem_req, 1'b0);
    chk("stall_valid", if_valid, 1'b1);
    chk("stall_pc", PC, 32'h4);
    imem_ack = 1'b0;
    id_ready = 1'b1;
    step();
    chk("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 32'h8);

    // Redirect while the request to 0x8 is in flight
    id_ready     = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("discard_addr_held", imem_addr, 32'h8);
    chk("discard_flushed", if_valid, 1'b0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0008;
    step();
    chk("discard_dropped", if_valid, 1'b0);
    chk("redirect_addr", imem_addr, 32'h100);
    imem_rdata = 32'hC000_0100;
    id_ready   = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("redirect_valid", if_valid, 1'b1);
    chk("redirect_pc", PC, 32'h104);
    chk("redirect_instr", instr, 32'hC000_0100);

    // Redirect coincident with an ack
    imem_ack     = 1'b1;
    imem_rdata   = 32'hDEAD_0104;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step();
    chk("ackbr_flushed", if_valid, 1'b0);
    chk("ackbr_addr", imem_addr, 32'h200);

    // Address wrap at the top of the space
    branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'hC0FF_EE00;
    step();
    imem_ack = 1'b0;
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

`ifdef IF_STALL_CNT_EN
    // Stall counter: 7 back-pressured valid cycles, then reset mid-stall
    do_reset();
    id_ready = 1'b0;
    acks  = 0;
    guard = 0;
    step();
    while (acks < 7 && guard < 50) begin
      imem_ack = imem_req;
      if (if_valid) acks++;
      guard++;
      step();
    end
    chk("stall_cnt_loop", acks, 7);
    chk("stall_cnt_7", stall_cnt, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("stall_cnt_reset", stall_cnt, 32'd0);
    step();
    rst_n = 1'b1;
`endif

    // Randomized traffic, with one reset in the middle of a request
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      imem_ack     = ($urandom_range(0, 1) == 1);
      imem_rdata   = $urandom;
      id_ready     = ($urandom_range(0, 9) < 6);
      branch_taken = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       branch_addr = 32'hFFFF_FFF8;
        default: branch_addr = $urandom & 32'hFFFF_FFFC;
      endcase
    end
    step();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_if_stage_fetch_unit

`default_nettype wire
